// File: rtl/onehot_queue_encoder32_pkg.sv
// Shared constants, state type and helpers for the 32-bit one-hot/request queue encoder.
// Only a 32-bit request vector with 5-bit indices is supported.
package enc_pkg;

    localparam int ENC_WIDTH = 32;
    localparam int ENC_IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;

    // True when exactly one bit is set; clearing the lowest set bit must leave zero.
    function automatic logic onehot_count_is_one(input logic [ENC_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - ENC_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_queue_encoder32_if.sv
// Request-vector input and serialized index output handshakes of the queue encoder.
// The master side is the environment; the slave side is the encoder.
interface onehot_queue_encoder32_if;
    import enc_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [ENC_WIDTH-1:0] req_vec;
    logic                 out_valid;
    logic                 out_ready;
    logic [ENC_IDX_W-1:0] out_idx;
    logic                 out_last;
    logic                 busy;

    modport master (
        output req_valid, req_vec, out_ready,
        input  req_ready, out_valid, out_idx, out_last, busy
    );

    modport slave (
        input  req_valid, req_vec, out_ready,
        output req_ready, out_valid, out_idx, out_last, busy
    );

endinterface

// File: rtl/onehot_queue_encoder32_prio_enc32.sv
// Combinational 32-to-5 priority encoder; MSB_FIRST selects whether the highest or lowest set bit wins.
// idx is 0 when vec is all zero; any flags a non-empty vector.
module prio_enc32
    import enc_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [ENC_WIDTH-1:0] vec,
    output logic [ENC_IDX_W-1:0] idx,
    output logic                 any
);

    // The last matching assignment in the scan wins, so scan toward the winning end.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < ENC_WIDTH; i++) begin
                if (vec[i]) idx = ENC_IDX_W'(i);
            end
        end else begin
            for (int i = ENC_WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = ENC_IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/onehot_queue_encoder32.sv
// Latches a 32-bit request vector and drains it as a stream of 5-bit indices, one per cycle,
// in priority order, flagging the final index.
//
//   state | meaning
//   IDLE  | ready for a new vector, nothing pending
//   DRAIN | pending holds unsent bits; out_idx presents the next one
module onehot_queue_encoder32
    import enc_pkg::*;
#(
    parameter int WIDTH     = ENC_WIDTH,
    parameter int IDX_W     = ENC_IDX_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    onehot_queue_encoder32_if.slave  io
);

    enc_state_t       state;
    logic [WIDTH-1:0] pending;
    logic             req_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             last_bit;

    prio_enc32 #(.MSB_FIRST(MSB_FIRST)) u_prio_enc (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign last_bit = onehot_count_is_one(pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An all-zero vector is consumed here without ever leaving IDLE.
                    if (io.req_valid && (io.req_vec != '0)) begin
                        pending     <= io.req_vec;
                        state       <= DRAIN;
                        req_ready_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (io.out_ready) begin
                        pending[enc_idx] <= 1'b0;
                        if (last_bit) begin
                            state       <= IDLE;
                            req_ready_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    pending     <= '0;
                    req_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign io.req_ready = req_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.busy      = busy_q;
    assign io.out_idx   = (out_valid_q && enc_any) ? enc_idx : '0;
    assign io.out_last  = out_valid_q && last_bit;

endmodule

// File: tb/tb_onehot_queue_encoder32.sv
// Drives an LSB-first and an MSB-first encoder in lockstep and checks both index streams
// against queues built directly from the set bits of each accepted vector.
module tb_onehot_queue_encoder32;
    import enc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    onehot_queue_encoder32_if i0 ();
    onehot_queue_encoder32_if i1 ();

    onehot_queue_encoder32 #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .io(i0));
    onehot_queue_encoder32 #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .io(i1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] vec, input logic ordy);
        i0.req_valid = rv;  i0.req_vec = vec;  i0.out_ready = ordy;
        i1.req_valid = rv;  i1.req_vec = vec;  i1.out_ready = ordy;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " lsb req_ready"}, 32'(i0.req_ready), 1);
        chk({tag, " lsb out_valid"}, 32'(i0.out_valid), 0);
        chk({tag, " lsb out_idx"},   32'(i0.out_idx),   0);
        chk({tag, " lsb out_last"},  32'(i0.out_last),  0);
        chk({tag, " lsb busy"},      32'(i0.busy),      0);
        chk({tag, " msb req_ready"}, 32'(i1.req_ready), 1);
        chk({tag, " msb out_valid"}, 32'(i1.out_valid), 0);
        chk({tag, " msb out_idx"},   32'(i1.out_idx),   0);
        chk({tag, " msb busy"},      32'(i1.busy),      0);
    endtask

    task automatic chk_drain(input string tag, input int exp_lsb, input int exp_msb, input bit last);
        chk({tag, " lsb out_valid"}, 32'(i0.out_valid), 1);
        chk({tag, " lsb out_idx"},   32'(i0.out_idx),   exp_lsb);
        chk({tag, " lsb out_last"},  32'(i0.out_last),  32'(last));
        chk({tag, " lsb req_ready"}, 32'(i0.req_ready), 0);
        chk({tag, " lsb busy"},      32'(i0.busy),      1);
        chk({tag, " msb out_valid"}, 32'(i1.out_valid), 1);
        chk({tag, " msb out_idx"},   32'(i1.out_idx),   exp_msb);
        chk({tag, " msb out_last"},  32'(i1.out_last),  32'(last));
    endtask

    // Send one vector and drain it; out_ready is held low for stall_first cycles,
    // then dropped at random with probability stall_pct percent.
    task automatic run_vector(input string tag, input logic [31:0] v,
                              input int stall_first, input int stall_pct);
        int q_lsb[$];
        int q_msb[$];
        int cyc;
        bit ordy;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                q_lsb.push_back(i);
                q_msb.push_front(i);
            end
        end
        @(negedge clk);
        chk_idle({tag, " pre"});
        drive(1'b1, v, 1'($urandom));
        @(negedge clk);
        cyc = 0;
        while (q_lsb.size() > 0) begin
            chk_drain(tag, q_lsb[0], q_msb[0], q_lsb.size() == 1);
            ordy = (cyc >= stall_first) && (int'($urandom_range(99)) >= stall_pct);
            drive(1'($urandom), $urandom, ordy);
            if (ordy) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
            cyc++;
            @(negedge clk);
            if (cyc > 400) begin
                chk({tag, " drain budget"}, q_lsb.size(), 0);
                break;
            end
        end
        chk_idle({tag, " done"});
        drive(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        run_vector("single", 32'h0000_0400, 0, 0);
        run_vector("multi",  32'h8000_0011, 0, 0);
        run_vector("bp",     32'h0000_0006, 3, 0);
        run_vector("zero",   32'h0000_0000, 0, 0);

        // Reset in the middle of draining an all-ones vector.
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk_drain("rstmid", k, 31 - k, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk_idle("after rst");
        run_vector("post rst", 32'h0000_0008, 0, 0);

        repeat (25) begin
            case ($urandom % 4)
                0: v = $urandom;
                1: v = $urandom & $urandom & $urandom;
                2: v = 32'h1 << ($urandom % 32);
                default: v = ($urandom % 3 == 0) ? 32'h0 : ($urandom & $urandom);
            endcase
            run_vector("rand", v, int'($urandom_range(2)), int'($urandom_range(50)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
